// File: rtl/mem_wb_pipe_pkg.sv
// Shared constants and the default-width stage record for the MEM->WB pipe.
// MEM_WB_LLBIT_EN adds the LL/SC link-bit fields to the record.
package mem_wb_pipe_pkg;

  localparam int RegAddrBus = 5;
  localparam int RegBus     = 32;

  localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
  localparam logic [RegBus-1:0]     ZeroWord     = '0;
  localparam logic                  RstEnable    = 1'b1;
  localparam logic                  WriteEnable  = 1'b1;
  localparam logic                  WriteDisable = 1'b0;

  typedef struct packed {
    logic [RegAddrBus-1:0] wd;
    logic                  wreg;
    logic [RegBus-1:0]     wdata;
    logic [RegBus-1:0]     hi;
    logic [RegBus-1:0]     lo;
    logic                  whilo;
`ifdef MEM_WB_LLBIT_EN
    logic                  llbit_we;
    logic                  llbit_value;
`endif
  } stage_t;

endpackage

// File: rtl/mem_wb_stage.sv
// One MEM->WB register slot. Priority: reset > flush > hold > bubble > load.
// The record type is a parameter so the top can pass its own widths.
module mem_wb_stage
  import mem_wb_pipe_pkg::*;
#(
  parameter type T = stage_t
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic flush_i,
  input  logic hold_i,
  input  logic bubble_i,
  input  logic load_i,
  input  T     d_i,
  output T     q_o
);

  T q_q, q_d;

  // Bubbles zero the whole record, not just the enables.
  always_comb begin
    q_d = q_q;
    if (flush_i)       q_d = '0;
    else if (hold_i)   q_d = q_q;
    else if (bubble_i) q_d = '0;
    else if (load_i)   q_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable) q_q <= '0;
    else                    q_q <= q_d;
  end

  assign q_o = q_q;

endmodule

// File: rtl/mem_wb_pipe.sv
// Parametrised MEM->WB pipeline (1..4 slots) with stall/bubble/flush, forwarding
// lookup and a committed-write counter. MEM_WB_LLBIT_EN adds the LL/SC link bit.
module mem_wb_pipe
  import mem_wb_pipe_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32,
  parameter int STAGES     = 1,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_mem,
  input  logic                  stall_wb,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_hi,
  input  logic [DATA_W-1:0]     mem_lo,
  input  logic                  mem_whilo,
  output logic [REG_ADDR_W-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [DATA_W-1:0]     wb_wdata,
  output logic [DATA_W-1:0]     wb_hi,
  output logic [DATA_W-1:0]     wb_lo,
  output logic                  wb_whilo,
  input  logic [REG_ADDR_W-1:0] fwd_addr,
  output logic                  fwd_hit,
  output logic [DATA_W-1:0]     fwd_data,
  output logic [CNT_W-1:0]      commit_cnt
`ifdef MEM_WB_LLBIT_EN
  ,
  input  logic                  mem_llbit_we,
  input  logic                  mem_llbit_value,
  output logic                  wb_llbit_we,
  output logic                  wb_llbit_value
`endif
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("mem_wb_pipe: STAGES must be in 1..4");
  end

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     hi;
    logic [DATA_W-1:0]     lo;
    logic                  whilo;
`ifdef MEM_WB_LLBIT_EN
    logic                  llbit_we;
    logic                  llbit_value;
`endif
  } slot_t;

  slot_t slot_in;
  slot_t stg_d [STAGES];
  slot_t stg_q [STAGES];

  always_comb begin
    slot_in       = '0;
    slot_in.wd    = mem_wd;
    slot_in.wreg  = mem_wreg;
    slot_in.wdata = mem_wdata;
    slot_in.hi    = mem_hi;
    slot_in.lo    = mem_lo;
    slot_in.whilo = mem_whilo;
`ifdef MEM_WB_LLBIT_EN
    slot_in.llbit_we    = mem_llbit_we;
    slot_in.llbit_value = mem_llbit_value;
`endif
  end

  // stall_mem=0 with stall_wb=1 is illegal; stall_wb alone already means hold.
  for (genvar i = 0; i < STAGES; i++) begin : g_stg
    if (i == 0) begin : g_head
      assign stg_d[i] = slot_in;
    end else begin : g_body
      assign stg_d[i] = stg_q[i-1];
    end

    mem_wb_stage #(.T(slot_t)) u_stage (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
      .hold_i  (stall_wb),
      .bubble_i(i == 0 ? stall_mem : 1'b0),
      .load_i  (i == 0 ? !stall_mem : 1'b1),
      .d_i     (stg_d[i]),
      .q_o     (stg_q[i])
    );
  end

  assign wb_wd    = stg_q[STAGES-1].wd;
  assign wb_wreg  = stg_q[STAGES-1].wreg;
  assign wb_wdata = stg_q[STAGES-1].wdata;
  assign wb_hi    = stg_q[STAGES-1].hi;
  assign wb_lo    = stg_q[STAGES-1].lo;
  assign wb_whilo = stg_q[STAGES-1].whilo;

  // Scan oldest to youngest so the youngest match overwrites; output slot excluded.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int i = STAGES - 2; i >= 0; i--) begin
      if (stg_q[i].wreg && stg_q[i].wd == fwd_addr && fwd_addr != '0) begin
        fwd_hit  = 1'b1;
        fwd_data = stg_q[i].wdata;
      end
    end
  end

  logic             held;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign held  = stall_wb & ~flush;
  assign cnt_d = cnt_q + CNT_W'((wb_wreg == WriteEnable) && !held);

  always_ff @(posedge clk) begin
    if (rst == RstEnable) cnt_q <= '0;
    else                  cnt_q <= cnt_d;
  end

  assign commit_cnt = cnt_q;

`ifdef MEM_WB_LLBIT_EN
  // A flush clears the link bit on the following cycle.
  logic flush_q;

  always_ff @(posedge clk) begin
    if (rst == RstEnable) flush_q <= 1'b0;
    else                  flush_q <= flush;
  end

  assign wb_llbit_we    = stg_q[STAGES-1].llbit_we | flush_q;
  assign wb_llbit_value = stg_q[STAGES-1].llbit_value;
`endif

  a_illegal_stall: assert property (@(posedge clk) disable iff (rst) !(stall_wb && !stall_mem))
    else $error("mem_wb_pipe: stall_wb without stall_mem");

endmodule
